// File: rtl/hdlc_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// hdlc_rx_frame_ctrl
//
// Frame-level controller for the HDLC receive path. Consumes the one-cycle
// flag / abort / new-byte strobes from the Rx shifter and zero-removal logic,
// tracks frame boundaries, writes received bytes into the Rx frame buffer and
// reports abort, overflow, end-of-frame and short-frame conditions.
//
// Parameters
//   MAX_BYTES  Rx buffer depth in bytes; bytes beyond this set Rx_Overflow
//   MIN_BYTES  minimum valid frame length (address+control+FCS)
//   AW         buffer address width
//
// Ports
//   Clk             in   system clock, all logic on posedge
//   Rst             in   synchronous reset, active-low
//   RxEN            in   receiver enable; low forces IDLE and clears outputs
//   Rx_FlagDetect   in   strobe: flag sequence recognised
//   Rx_AbortDetect  in   strobe: abort sequence recognised
//   Rx_NewByte      in   strobe: Rx_Data holds a de-stuffed byte
//   Rx_Data         in   received byte
//   Rx_FrameRead    in   host pulse: frame consumed, release buffer
//   Rx_ValidFrame   out  high while inside a frame
//   Rx_WrBuff       out  buffer write strobe
//   Rx_WrAddr       out  buffer write address
//   Rx_WrData       out  buffer write data
//   Rx_AbortSignal  out  pulse: abort inside a frame
//   Rx_Overflow     out  sticky: frame exceeded MAX_BYTES
//   Rx_EoF          out  pulse: good closing flag received
//   Rx_FrameError   out  pulse: closing flag on a too-short frame
//   Rx_FrameSize    out  byte count of the completed frame
//   Rx_Ready        out  frame available for the host
// -----------------------------------------------------------------------------
module hdlc_rx_frame_ctrl #(
  parameter int MAX_BYTES = 128,
  parameter int MIN_BYTES = 4,
  parameter int AW        = $clog2(MAX_BYTES)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          RxEN,
  input  logic          Rx_FlagDetect,
  input  logic          Rx_AbortDetect,
  input  logic          Rx_NewByte,
  input  logic [7:0]    Rx_Data,
  input  logic          Rx_FrameRead,
  output logic          Rx_ValidFrame,
  output logic          Rx_WrBuff,
  output logic [AW-1:0] Rx_WrAddr,
  output logic [7:0]    Rx_WrData,
  output logic          Rx_AbortSignal,
  output logic          Rx_Overflow,
  output logic          Rx_EoF,
  output logic          Rx_FrameError,
  output logic [AW:0]   Rx_FrameSize,
  output logic          Rx_Ready
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_MAX = CW'(MAX_BYTES);
  localparam logic [CW-1:0] L_MIN = CW'(MIN_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HUNT  = 2'd1,
    S_FRAME = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state,       w_state;
  logic [CW-1:0] r_count,       w_count;
  logic          r_valid_frame, w_valid_frame;
  logic          r_wr_buff,     w_wr_buff;
  logic [AW-1:0] r_wr_addr,     w_wr_addr;
  logic [7:0]    r_wr_data,     w_wr_data;
  logic          r_abort,       w_abort;
  logic          r_overflow,    w_overflow;
  logic          r_eof,         w_eof;
  logic          r_frame_error, w_frame_error;
  logic [CW-1:0] r_frame_size,  w_frame_size;
  logic          r_ready,       w_ready;

  // Byte count after accepting this cycle's byte; a coincident flag is judged
  // against this value, so the byte is always counted before the flag.
  logic [CW-1:0] w_count_upd;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_state       = r_state;
    w_count       = r_count;
    w_valid_frame = r_valid_frame;
    w_wr_buff     = 1'b0;
    w_wr_addr     = r_wr_addr;
    w_wr_data     = r_wr_data;
    w_abort       = 1'b0;
    w_overflow    = r_overflow;
    w_eof         = 1'b0;
    w_frame_error = 1'b0;
    w_frame_size  = r_frame_size;
    w_ready       = r_ready;
    w_count_upd   = r_count;

    if (!RxEN) begin
      // Receiver disabled: discard everything silently, no abort pulse.
      w_state       = S_IDLE;
      w_count       = '0;
      w_valid_frame = 1'b0;
      w_wr_addr     = '0;
      w_wr_data     = '0;
      w_overflow    = 1'b0;
      w_frame_size  = '0;
      w_ready       = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state = S_HUNT;
        end

        S_HUNT: begin
          // Abort takes precedence over a coincident flag.
          if (Rx_FlagDetect && !Rx_AbortDetect) begin
            w_state       = S_FRAME;
            w_count       = '0;
            w_overflow    = 1'b0;
            w_valid_frame = 1'b1;
          end
        end

        S_FRAME: begin
          if (Rx_AbortDetect) begin
            // A byte arriving with the abort is dropped.
            w_state       = S_HUNT;
            w_count       = '0;
            w_valid_frame = 1'b0;
            w_abort       = 1'b1;
          end else begin
            if (Rx_NewByte) begin
              if (r_count < L_MAX) begin
                w_wr_buff   = 1'b1;
                w_wr_addr   = r_count[AW-1:0];
                w_wr_data   = Rx_Data;
                w_count_upd = r_count + CW'(1);
              end else begin
                w_overflow  = 1'b1;
              end
            end
            w_count = w_count_upd;

            if (Rx_FlagDetect) begin
              if (w_count_upd == '0) begin
                // Shared or back-to-back flag: still waiting for data.
                w_count = '0;
              end else if (w_count_upd < L_MIN) begin
                // Too short; the flag doubles as the next opening flag.
                w_frame_error = 1'b1;
                w_count       = '0;
                w_overflow    = 1'b0;
              end else begin
                w_eof         = 1'b1;
                w_frame_size  = w_count_upd;
                w_valid_frame = 1'b0;
                w_ready       = 1'b1;
                w_count       = '0;
                w_state       = S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          // Frame held for the host; line strobes are ignored here.
          if (Rx_FrameRead) begin
            w_state    = S_HUNT;
            w_ready    = 1'b0;
            w_overflow = 1'b0;
          end
        end

        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_valid_frame <= 1'b0;
      r_wr_buff     <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_abort       <= 1'b0;
      r_overflow    <= 1'b0;
      r_eof         <= 1'b0;
      r_frame_error <= 1'b0;
      r_frame_size  <= '0;
      r_ready       <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_count       <= w_count;
      r_valid_frame <= w_valid_frame;
      r_wr_buff     <= w_wr_buff;
      r_wr_addr     <= w_wr_addr;
      r_wr_data     <= w_wr_data;
      r_abort       <= w_abort;
      r_overflow    <= w_overflow;
      r_eof         <= w_eof;
      r_frame_error <= w_frame_error;
      r_frame_size  <= w_frame_size;
      r_ready       <= w_ready;
    end
  end

  assign Rx_ValidFrame  = r_valid_frame;
  assign Rx_WrBuff      = r_wr_buff;
  assign Rx_WrAddr      = r_wr_addr;
  assign Rx_WrData      = r_wr_data;
  assign Rx_AbortSignal = r_abort;
  assign Rx_Overflow    = r_overflow;
  assign Rx_EoF         = r_eof;
  assign Rx_FrameError  = r_frame_error;
  assign Rx_FrameSize   = r_frame_size;
  assign Rx_Ready       = r_ready;

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdlc_rx_frame_ctrl
//
// Directed self-checking bench for hdlc_rx_frame_ctrl (MAX_BYTES=128,
// MIN_BYTES=4). Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, so each check sees the registered response
// to the strobe applied in the preceding cycle.
// -----------------------------------------------------------------------------
module tb_hdlc_rx_frame_ctrl;

  localparam int AW = 7;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          RxEN;
  logic          Rx_FlagDetect;
  logic          Rx_AbortDetect;
  logic          Rx_NewByte;
  logic [7:0]    Rx_Data;
  logic          Rx_FrameRead;
  logic          Rx_ValidFrame;
  logic          Rx_WrBuff;
  logic [AW-1:0] Rx_WrAddr;
  logic [7:0]    Rx_WrData;
  logic          Rx_AbortSignal;
  logic          Rx_Overflow;
  logic          Rx_EoF;
  logic          Rx_FrameError;
  logic [AW:0]   Rx_FrameSize;
  logic          Rx_Ready;

  int total = 0;
  int bad   = 0;

  hdlc_rx_frame_ctrl #(.MAX_BYTES(128), .MIN_BYTES(4)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .RxEN           (RxEN),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_NewByte     (Rx_NewByte),
    .Rx_Data        (Rx_Data),
    .Rx_FrameRead   (Rx_FrameRead),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_WrBuff      (Rx_WrBuff),
    .Rx_WrAddr      (Rx_WrAddr),
    .Rx_WrData      (Rx_WrData),
    .Rx_AbortSignal (Rx_AbortSignal),
    .Rx_Overflow    (Rx_Overflow),
    .Rx_EoF         (Rx_EoF),
    .Rx_FrameError  (Rx_FrameError),
    .Rx_FrameSize   (Rx_FrameSize),
    .Rx_Ready       (Rx_Ready)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One cycle with the given strobes, then strobes back to idle.
  task automatic strobe(input logic flag, input logic abort, input logic nb,
                        input logic [7:0] data, input logic rd);
    Rx_FlagDetect  = flag;
    Rx_AbortDetect = abort;
    Rx_NewByte     = nb;
    Rx_Data        = data;
    Rx_FrameRead   = rd;
    tick();
    Rx_FlagDetect  = 1'b0;
    Rx_AbortDetect = 1'b0;
    Rx_NewByte     = 1'b0;
    Rx_FrameRead   = 1'b0;
  endtask

  task automatic flag();             strobe(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic abort();            strobe(1'b0, 1'b1, 1'b0, 8'h00, 1'b0); endtask
  task automatic byte_in(input logic [7:0] d); strobe(1'b0, 1'b0, 1'b1, d, 1'b0); endtask
  task automatic idle();             strobe(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); endtask
  task automatic frame_read();       strobe(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); endtask

  // Packs every output; all-zero means the block is fully cleared.
  function automatic logic [31:0] all_outs();
    return {8'h00, Rx_ValidFrame, Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_AbortSignal,
            Rx_Overflow, Rx_EoF, Rx_FrameError, Rx_FrameSize, Rx_Ready};
  endfunction

  initial begin
    Rst = 1'b0; RxEN = 1'b0;
    Rx_FlagDetect = 1'b0; Rx_AbortDetect = 1'b0; Rx_NewByte = 1'b0;
    Rx_Data = 8'h00; Rx_FrameRead = 1'b0;
    tick(); tick();
    check("reset_outs", all_outs(), 32'h0);

    // ---- 1: ten-byte good frame ----
    Rst = 1'b1; RxEN = 1'b1;
    idle();                                    // IDLE -> HUNT
    check("hunt_valid", Rx_ValidFrame, 1'b0);
    flag();
    check("open_valid", Rx_ValidFrame, 1'b1);
    check("open_wr", Rx_WrBuff, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      byte_in(8'(i));
      check("t1_wr",   Rx_WrBuff, 1'b1);
      check("t1_addr", Rx_WrAddr, 32'(i - 1));
      check("t1_data", Rx_WrData, 32'(i));
    end
    flag();
    check("t1_eof",   Rx_EoF, 1'b1);
    check("t1_size",  Rx_FrameSize, 32'd10);
    check("t1_ready", Rx_Ready, 1'b1);
    check("t1_vf",    Rx_ValidFrame, 1'b0);
    check("t1_wr_off", Rx_WrBuff, 1'b0);
    check("t1_ferr",  Rx_FrameError, 1'b0);
    idle();
    check("t1_eof_pulse", Rx_EoF, 1'b0);
    check("t1_ready_hold", Rx_Ready, 1'b1);
    frame_read();
    check("t1_ready_clr", Rx_Ready, 1'b0);

    // ---- 2: abort inside a frame, then abort in HUNT ----
    flag();
    for (int i = 0; i < 5; i++) byte_in(8'hA0 + 8'(i));
    abort();
    check("t2_abort", Rx_AbortSignal, 1'b1);
    check("t2_vf",    Rx_ValidFrame, 1'b0);
    check("t2_eof",   Rx_EoF, 1'b0);
    idle();
    check("t2_abort_pulse", Rx_AbortSignal, 1'b0);
    abort();
    check("t2_hunt_abort", Rx_AbortSignal, 1'b0);
    flag();                                    // HUNT accepts a flag directly
    check("t2_reopen_vf", Rx_ValidFrame, 1'b1);

    // ---- 3: 130 bytes, overflow ----
    for (int i = 0; i < 130; i++) begin
      byte_in(8'(i) ^ 8'h5A);
      check("t3_wr", Rx_WrBuff, (i < 128) ? 1'b1 : 1'b0);
      if (i < 128) begin
        check("t3_addr", Rx_WrAddr, 32'(i));
        check("t3_data", Rx_WrData, 32'(8'(i) ^ 8'h5A));
      end
      check("t3_ovf", Rx_Overflow, (i >= 128) ? 1'b1 : 1'b0);
    end
    flag();
    check("t3_eof",  Rx_EoF, 1'b1);
    check("t3_size", Rx_FrameSize, 32'd128);
    check("t3_ovf_hold", Rx_Overflow, 1'b1);
    frame_read();
    check("t3_ovf_clr", Rx_Overflow, 1'b0);
    check("t3_ready_clr", Rx_Ready, 1'b0);

    // ---- 4: short frame then six-byte frame ----
    flag();
    byte_in(8'h11); byte_in(8'h22);
    flag();
    check("t4_ferr", Rx_FrameError, 1'b1);
    check("t4_eof0", Rx_EoF, 1'b0);
    check("t4_vf",   Rx_ValidFrame, 1'b1);
    idle();
    check("t4_ferr_pulse", Rx_FrameError, 1'b0);
    for (int i = 0; i < 6; i++) begin
      byte_in(8'h30 + 8'(i));
      check("t4_addr", Rx_WrAddr, 32'(i));
      check("t4_data", Rx_WrData, 32'(8'h30 + 8'(i)));
    end
    flag();
    check("t4_eof",  Rx_EoF, 1'b1);
    check("t4_size", Rx_FrameSize, 32'd6);
    frame_read();

    // ---- 5: shared flags; byte coincident with closing flag ----
    flag(); flag();
    check("t5_ferr_a", Rx_FrameError, 1'b0);
    flag();
    check("t5_ferr_b", Rx_FrameError, 1'b0);
    check("t5_vf",     Rx_ValidFrame, 1'b1);
    for (int i = 0; i < 4; i++) byte_in(8'h40 + 8'(i));
    flag();
    check("t5_eof",  Rx_EoF, 1'b1);
    check("t5_size", Rx_FrameSize, 32'd4);
    frame_read();
    flag();
    for (int i = 0; i < 3; i++) byte_in(8'h50 + 8'(i));
    strobe(1'b1, 1'b0, 1'b1, 8'h53, 1'b0);
    check("t5c_wr",   Rx_WrBuff, 1'b1);
    check("t5c_addr", Rx_WrAddr, 32'd3);
    check("t5c_data", Rx_WrData, 32'h53);
    check("t5c_eof",  Rx_EoF, 1'b1);
    check("t5c_ferr", Rx_FrameError, 1'b0);
    check("t5c_size", Rx_FrameSize, 32'd4);
    frame_read();

    // ---- 6: RxEN drop, Rst mid-frame, strobes in DONE ----
    flag();
    for (int i = 0; i < 3; i++) byte_in(8'h60 + 8'(i));
    RxEN = 1'b0;
    idle();
    check("t6_rxen_outs", all_outs(), 32'h0);
    RxEN = 1'b1;
    idle();                                    // IDLE -> HUNT
    flag();
    byte_in(8'h71); byte_in(8'h72);
    Rst = 1'b0;
    idle();
    check("t6_rst_outs", all_outs(), 32'h0);
    Rst = 1'b1;
    idle();                                    // IDLE -> HUNT
    flag();
    for (int i = 0; i < 4; i++) byte_in(8'h80 + 8'(i));
    flag();
    check("t6_eof", Rx_EoF, 1'b1);
    flag();
    check("t6_done_eof", Rx_EoF, 1'b0);
    byte_in(8'hEE);
    check("t6_done_wr",   Rx_WrBuff, 1'b0);
    check("t6_done_size", Rx_FrameSize, 32'd4);
    abort();
    check("t6_done_abort", Rx_AbortSignal, 1'b0);
    check("t6_done_ready", Rx_Ready, 1'b1);
    frame_read();
    check("t6_read_ready", Rx_Ready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
